// File: rtl/mux_1bit_2to1.sv
// Single-bit 2:1 selector with a combinational result, a registered copy,
// and saturating counters for select transitions and enabled b-selects.
module mux_1bit_2to1 #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a,
    input  logic             b,
    input  logic             s,
    input  logic             en,
    output logic             res,
    output logic             res_q,
    output logic [CNT_W-1:0] sw_cnt,
    output logic [CNT_W-1:0] bsel_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic s_prev;
    logic sw_hit;
    logic bsel_hit;

    assign res      = s ? b : a;
    assign sw_hit   = (s != s_prev) && (sw_cnt != CNT_MAX);
    assign bsel_hit = en && s && (bsel_cnt != CNT_MAX);

    // s_prev clears to 0, so a high s on the first cycle after reset counts as a transition
    always_ff @(posedge clk) begin
        if (rst) begin
            res_q    <= 1'b0;
            s_prev   <= 1'b0;
            sw_cnt   <= '0;
            bsel_cnt <= '0;
        end else begin
            s_prev <= s;
            if (en) begin
                res_q <= res;
            end
            if (sw_hit) begin
                sw_cnt <= sw_cnt + CNT_ONE;
            end
            if (bsel_hit) begin
                bsel_cnt <= bsel_cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_mux_1bit_2to1.sv
// Directed bench for mux_1bit_2to1: truth table, registered path, reset priority,
// transition/b-select counting and saturation on a narrow-counter instance.
module tb_mux_1bit_2to1;

    logic        clk = 1'b0;
    logic        rst, a, b, s, en;
    logic        res, res_q;
    logic [15:0] sw_cnt, bsel_cnt;
    logic        res2, res_q2;
    logic [1:0]  sw_cnt2, bsel_cnt2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mux_1bit_2to1 dut (
        .clk(clk), .rst(rst), .a(a), .b(b), .s(s), .en(en),
        .res(res), .res_q(res_q), .sw_cnt(sw_cnt), .bsel_cnt(bsel_cnt)
    );

    mux_1bit_2to1 #(.CNT_W(2)) dut_w2 (
        .clk(clk), .rst(rst), .a(a), .b(b), .s(s), .en(en),
        .res(res2), .res_q(res_q2), .sw_cnt(sw_cnt2), .bsel_cnt(bsel_cnt2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // truth vectors {a,b,s,expected res}
    logic [3:0] tt [6] = '{4'b0000, 4'b1001, 4'b0111, 4'b1111, 4'b1010, 4'b0100};
    logic [4:0] s_seq = 5'b10110;   // driven MSB first: 1,0,1,1,0
    int         sw_exp2 [6] = '{1, 2, 3, 3, 3, 3};

    initial begin
        rst = 1'b1; a = 1'b0; b = 1'b0; s = 1'b0; en = 1'b0;

        // combinational truth table with reset held high
        foreach (tt[i]) begin
            a = tt[i][3]; b = tt[i][2]; s = tt[i][1];
            #10;
            chk($sformatf("truth%0d", i), {31'd0, res}, {31'd0, tt[i][0]});
        end
        chk("rst_res_q", {31'd0, res_q}, 32'd0);
        chk("rst_sw", {16'd0, sw_cnt}, 32'd0);
        chk("rst_bsel", {16'd0, bsel_cnt}, 32'd0);

        // registered path
        rst = 1'b0; en = 1'b1; a = 1'b1; b = 1'b0; s = 1'b0;
        step();
        chk("load_res_q", {31'd0, res_q}, 32'd1);
        en = 1'b0; a = 1'b0;
        step();
        chk("hold_res_q", {31'd0, res_q}, 32'd1);
        chk("hold_res", {31'd0, res}, 32'd0);

        // reset wins over en with res=1
        rst = 1'b1; en = 1'b1; a = 1'b1;
        step();
        chk("rprio_res_q", {31'd0, res_q}, 32'd0);
        chk("rprio_sw", {16'd0, sw_cnt}, 32'd0);
        chk("rprio_bsel", {16'd0, bsel_cnt}, 32'd0);

        // transition counting, en high
        rst = 1'b0; en = 1'b1; a = 1'b0; b = 1'b0;
        for (int i = 4; i >= 0; i--) begin
            s = s_seq[i];
            step();
        end
        chk("cnt_en_sw", {16'd0, sw_cnt}, 32'd4);
        chk("cnt_en_bsel", {16'd0, bsel_cnt}, 32'd3);

        // transition counting, en low
        rst = 1'b1; s = 1'b0;
        step();
        rst = 1'b0; en = 1'b0;
        for (int i = 4; i >= 0; i--) begin
            s = s_seq[i];
            step();
        end
        chk("cnt_dis_sw", {16'd0, sw_cnt}, 32'd4);
        chk("cnt_dis_bsel", {16'd0, bsel_cnt}, 32'd0);

        // mid-run reset with counters nonzero
        a = 1'b0; b = 1'b1; s = 1'b1; en = 1'b1; rst = 1'b1;
        step();
        chk("mid_res_q", {31'd0, res_q}, 32'd0);
        chk("mid_sw", {16'd0, sw_cnt}, 32'd0);
        chk("mid_bsel", {16'd0, bsel_cnt}, 32'd0);
        rst = 1'b0;
        step();
        chk("resume_res_q", {31'd0, res_q}, 32'd1);
        chk("resume_sw", {16'd0, sw_cnt}, 32'd1);
        chk("resume_bsel", {16'd0, bsel_cnt}, 32'd1);
        step();
        chk("resume2_sw", {16'd0, sw_cnt}, 32'd1);
        chk("resume2_bsel", {16'd0, bsel_cnt}, 32'd2);

        // saturation on the 2-bit instance
        rst = 1'b1; s = 1'b0; en = 1'b0;
        step();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            s = ~s;
            step();
            chk($sformatf("sat_sw%0d", i), {30'd0, sw_cnt2}, sw_exp2[i]);
        end
        chk("sat_bsel", {30'd0, bsel_cnt2}, 32'd0);
        chk("wide_sw", {16'd0, sw_cnt}, 32'd6);
        step();
        chk("sat_hold", {30'd0, sw_cnt2}, 32'd3);
        rst = 1'b1;
        step();
        chk("sat_clear", {30'd0, sw_cnt2}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
